// File: rtl/mem_port_arb.sv
// mem_port_arb
//   Shares one external memory port between L1 I$ refill requests and L1 D$
//   refill/writeback requests. One transaction is in flight at a time. The grant
//   is registered. Ties are broken round-robin, or always in favour of the D$
//   when FIXED_PRI != 0. A per-transaction timeout returns a fault to the
//   requester; TMO = 0 disables the timeout.
//
// Ports
//   clk_in, reset_in        clock, asynchronous active-low reset
//   ic_req/ic_addr          I$ request, held until ic_ack
//   ic_ack/_data/_fault     1-cycle completion pulse with read data and fault
//   dc_req/dc_addr/dc_wr/   D$ request (dc_wr=1 writeback), held until dc_ack
//     dc_wr_data
//   dc_ack/_data/_fault     1-cycle completion pulse (data 0 on writes)
//   mem_req/addr/wr/wr_data memory request, held until mem_ack or timeout
//   mem_ack/_data/_fault    memory completion pulse with read data and fault
//   busy                    arbiter not idle
module mem_port_arb #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 128,
  parameter int unsigned TMO       = 255,
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          ic_req,
  input  logic [AW-1:0] ic_addr,
  output logic          ic_ack,
  output logic [DW-1:0] ic_ack_data,
  output logic          ic_ack_fault,
  input  logic          dc_req,
  input  logic [AW-1:0] dc_addr,
  input  logic          dc_wr,
  input  logic [DW-1:0] dc_wr_data,
  output logic          dc_ack,
  output logic [DW-1:0] dc_ack_data,
  output logic          dc_ack_fault,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wr_data,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_ack_data,
  input  logic          mem_ack_fault,
  output logic          busy
);

  // The counter runs 0..TMO-1 across the BUSY cycles. The last value marks the
  // TMO-th BUSY cycle, which is where the timeout fires.
  localparam int unsigned   TW       = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TMO == 0) ? '0 : TW'(TMO - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IC, BUSY_DC, RESP} state_t;

  state_t        state, state_nxt;
  logic          last_dc;
  logic          any_req, grant_dc, in_busy, tmo_hit;
  logic [TW-1:0] tmo_cnt;
  logic [DW-1:0] rsp_data;
  logic          rsp_fault;

  always_comb begin
    any_req = ic_req | dc_req;
    if (ic_req && dc_req) grant_dc = (FIXED_PRI != 0) ? 1'b1 : ~last_dc;
    else                  grant_dc = dc_req;
    in_busy = (state == BUSY_IC) || (state == BUSY_DC);
    tmo_hit = (TMO != 0) && (tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // mem_ack takes priority over a timeout in the same cycle. Both lead to RESP,
  // and the datapath below records which one it was.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:             if (any_req) state_nxt = grant_dc ? BUSY_DC : BUSY_IC;
      BUSY_IC, BUSY_DC: if (mem_ack || tmo_hit) state_nxt = RESP;
      RESP:             state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      last_dc     <= 1'b1;
      mem_addr    <= '0;
      mem_wr      <= 1'b0;
      mem_wr_data <= '0;
      rsp_data    <= '0;
      rsp_fault   <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (any_req) begin
            last_dc     <= grant_dc;
            mem_addr    <= grant_dc ? dc_addr : ic_addr;
            mem_wr      <= grant_dc & dc_wr;
            mem_wr_data <= grant_dc ? dc_wr_data : '0;
          end
        end
        BUSY_IC, BUSY_DC: begin
          if (mem_ack) begin
            rsp_data  <= mem_wr ? '0 : mem_ack_data;
            rsp_fault <= mem_ack_fault;
          end else if (tmo_hit) begin
            rsp_data  <= '0;
            rsp_fault <= 1'b1;
          end else if (TMO != 0) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: tmo_cnt <= '0;
      endcase
    end
  end

  // last_dc still names the in-flight source during RESP. It therefore routes
  // the ack without a separate "response owner" register.
  always_comb begin
    mem_req      = in_busy;
    busy         = (state != IDLE);
    ic_ack       = (state == RESP) && !last_dc;
    dc_ack       = (state == RESP) &&  last_dc;
    ic_ack_data  = ic_ack ? rsp_data : '0;
    ic_ack_fault = ic_ack & rsp_fault;
    dc_ack_data  = dc_ack ? rsp_data : '0;
    dc_ack_fault = dc_ack & rsp_fault;
  end

endmodule
